// File: rtl/mac_operand_loader.sv
// rtl/mac_operand_loader.sv - stream-to-RAM burst loader owning the 256x16 MAC operand memory
module mac_operand_loader #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] LEN_ONE = (ADDR_W + 1)'(1);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   remaining_q, remaining_d;
    logic              err_q, err_d;
    logic              wr_en;
    logic [DATA_W-1:0] rd_data_a_q, rd_data_b_q;

    logic [DATA_W-1:0] mem [DEPTH];

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        remaining_d = remaining_q;
        err_d       = err_q;
        wr_en       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    wr_ptr_d    = base_addr;
                    remaining_d = length;
                    err_d       = 1'b0;
                    if (length != '0 && length <= LEN_MAX) begin
                        state_d = S_LOAD;
                    end else begin
                        // Illegal length: flag it and finish without touching the RAM.
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_LOAD: begin
                if (in_valid) begin
                    wr_en       = 1'b1;
                    wr_ptr_d    = wr_ptr_q + 1'b1;
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == LEN_ONE) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            remaining_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            remaining_q <= remaining_d;
            err_q       <= err_d;
        end
    end

    // RAM array is deliberately not reset; nonblocking write gives old-data read-during-write.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_a_q <= '0;
            rd_data_b_q <= '0;
        end else begin
            rd_data_a_q <= mem[rd_addr_a];
            rd_data_b_q <= mem[rd_addr_b];
        end
    end

    assign in_ready  = (state_q == S_LOAD);
    assign busy      = (state_q == S_LOAD);
    assign done      = (state_q == S_DONE);
    assign err       = err_q;
    assign rd_data_a = rd_data_a_q;
    assign rd_data_b = rd_data_b_q;

endmodule
